// File: rtl/mem_burst_reader.sv
// Burst read initiator for the simple dual-port RAM: issues rden/rdaddress, absorbs the 1-cycle read
// latency in a 2-entry buffer and streams words out on valid/ready. MEM_BURST_WRAP_EN enables line wrap.
module mem_burst_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int LEN_W = 4,
  parameter int LINE  = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic [AW-1:0]    mem_rdaddress,
  output logic             mem_rden,
  input  logic [WIDTH-1:0] mem_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_next;
  logic [AW-1:0]    r_addr, w_addr_next;
  logic [LEN_W:0]   r_issue_left, r_deliver_left;
  logic             r_inflight;
  logic [WIDTH-1:0] r_buf [0:1];
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop, w_rden, w_accept;
  logic [2:0]       w_occ;

  if (LINE < 1 || LINE > DEPTH || (1 << AW) != DEPTH) begin : g_param_check
    $error("mem_burst_reader: DEPTH must be a power of two and LINE within 1..DEPTH");
  end

`ifdef MEM_BURST_WRAP_EN
  localparam int LB = $clog2(LINE);
  logic [LB-1:0] w_line_off;
  assign w_line_off  = r_addr[LB-1:0] + 1'b1;
  assign w_addr_next = {r_addr[AW-1:LB], w_line_off};
`else
  assign w_addr_next = r_addr + 1'b1;
`endif

  assign out_valid     = (r_count != 2'd0);
  assign out_data      = out_valid ? r_buf[r_rd_ptr] : '0;
  assign out_last      = out_valid & (r_deliver_left == (LEN_W+1)'(1));
  assign w_pop         = out_valid & out_ready;
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight};
  assign mem_rden      = w_rden;
  assign mem_rdaddress = r_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    busy         = 1'b0;
    w_rden       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        // Words already buffered or in flight, less this cycle's pop, must leave a free slot.
        if (r_issue_left != '0 && w_occ <= 3'd1 + {2'b00, w_pop})
          w_rden = 1'b1;
        if (w_pop && out_last)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr         <= '0;
      r_issue_left   <= '0;
      r_deliver_left <= '0;
      r_inflight     <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_accept) begin
        r_addr         <= req_addr;
        r_issue_left   <= (LEN_W+1)'(req_len) + 1'b1;
        r_deliver_left <= (LEN_W+1)'(req_len) + 1'b1;
      end else begin
        if (w_rden) begin
          r_addr       <= w_addr_next;
          r_issue_left <= r_issue_left - 1'b1;
        end
        if (w_pop)
          r_deliver_left <= r_deliver_left - 1'b1;
      end
      r_inflight <= w_rden;
      if (r_inflight)
        r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by r_count.
  always_ff @(posedge clock) begin
    if (r_inflight)
      r_buf[r_wr_ptr] <= mem_q;
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: behavioural RAM, scoreboard queue of expected words,
// a table of bursts under several out_ready patterns, plus reset-mid-burst and busy-hold sequences.
module tb_mem_burst_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int LEN_W = 4;
  localparam int AW    = 6;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AW-1:0]    req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [AW-1:0]    mem_rdaddress;
  logic             mem_rden;
  logic [WIDTH-1:0] mem_q = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  always #5 clock = ~clock;

  mem_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W), .LINE(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  always @(posedge clock) if (mem_rden) mem_q <= mem[mem_rdaddress];

  typedef struct { logic [WIDTH-1:0] data; logic last; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int rden_cnt = 0;
  int pop_cnt = 0;
  int tb_occ = 0;
  int rmode = 0;
  int rphase = 0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [WIDTH-1:0] last_data = '0;
  bit pat [6] = '{1, 0, 1, 0, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within budget", name);
  endtask

  function automatic int nxt(input int a);
`ifdef MEM_BURST_WRAP_EN
    return (a & ~3) | ((a + 1) & 3);
`else
    return (a + 1) % DEPTH;
`endif
  endfunction

  task automatic push_burst(input int addr, input int len);
    int a;
    exp_t e;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      e.data = mem[a];
      e.last = (i == len);
      sb.push_back(e);
      a = nxt(a);
    end
  endtask

  // Monitor: scoreboard pop, stall stability, occupancy and idle-read checks
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      tb_occ = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      check("rden_idle", mem_rden & ~busy, 0);
      check("occupancy_le2", (tb_occ <= 2) ? 1 : 0, 1);
      if (mem_rden) rden_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got data %0d with nothing expected", out_data);
        end else begin
          e = sb.pop_front();
          $display("pop data=%0d last=%0d exp_data=%0d exp_last=%0d", out_data, out_last, e.data, e.last);
          check("data", out_data, e.data);
          check("last", out_last, e.last);
        end
        if (out_last) last_data = out_data;
      end
      tb_occ = tb_occ + (mem_rden ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        1: begin out_ready = pat[rphase % 6]; rphase++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      fail_now(name);
      sb.delete();
    end
  endtask

  task automatic run_burst(input int addr, input int len, input int mode, input int exp_last);
    int p0;
    rmode = mode;
    rphase = 0;
    @(posedge clock);
    #1;
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_addr = AW'(addr);
    req_len = LEN_W'(len);
    push_burst(addr, len);
    rden_cnt = 0;
    p0 = pop_cnt;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("lat_rden_e1", mem_rden, 1);
    check("lat_novalid_e1", out_valid, 0);
    @(negedge clock);
    check("lat_novalid_e2", out_valid, 0);
    @(negedge clock);
    check("lat_valid_e3", out_valid, 1);
    #1;
    wait_drain("burst_drain");
    @(negedge clock);
    check("req_ready_after", req_ready, 1);
    check("busy_after", busy, 0);
    check("rden_pulses", rden_cnt, len + 1);
    check("word_count", pop_cnt - p0, len + 1);
    check("last_word", last_data, exp_last);
    $display("burst addr=%0d len=%0d mode=%0d words=%0d last=%0d", addr, len, mode, pop_cnt - p0, last_data);
  endtask

  typedef struct { int addr; int len; int mode; int exp_last; } vec_t;
  vec_t vt [8];

  initial begin
    int n;
    int p0;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
`ifdef MEM_BURST_WRAP_EN
    vt[0] = '{5, 3, 0, 4};   vt[1] = '{5, 3, 1, 4};   vt[2] = '{62, 3, 0, 61};
    vt[3] = '{6, 3, 0, 5};   vt[4] = '{6, 5, 0, 7};   vt[5] = '{40, 15, 2, 43};
    vt[6] = '{33, 0, 0, 33}; vt[7] = '{7, 15, 1, 6};
`else
    vt[0] = '{5, 3, 0, 8};   vt[1] = '{5, 3, 1, 8};   vt[2] = '{62, 3, 0, 1};
    vt[3] = '{6, 3, 0, 9};   vt[4] = '{6, 5, 0, 11};  vt[5] = '{40, 15, 2, 55};
    vt[6] = '{33, 0, 0, 33}; vt[7] = '{7, 15, 1, 22};
`endif

    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_rden", mem_rden, 0);
    check("rst_rdaddress", mem_rdaddress, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 8; i++)
      run_burst(vt[i].addr, vt[i].len, vt[i].mode, vt[i].exp_last);

    // Reset after two words have been popped
    rmode = 0;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_addr = 6'd5;
    req_len = 4'd3;
    push_burst(5, 3);
    p0 = pop_cnt;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (pop_cnt - p0 < 2 && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (pop_cnt - p0 < 2) fail_now("reset_wait_pops");
    @(posedge clock);
    #2;
    check("pre_reset_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mem_rden", mem_rden, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_out_last", out_last, 0);
    check("midrst_out_data", out_data, 0);
    sb.delete();
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    run_burst(0, 0, 0, 0);

    // req_valid held high with a new request while busy
    rmode = 0;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_addr = 6'd10;
    req_len = 4'd15;
    push_burst(10, 15);
    rden_cnt = 0;
    @(posedge clock);
    #1;
    req_addr = 6'd20;
    req_len = 4'd1;
    push_burst(20, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      if (req_ready) break;
      n++;
    end
    if (!req_ready) fail_now("hold_second_accept");
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_drain("hold_drain");
    @(negedge clock);
    check("hold_rden_pulses", rden_cnt, 18);
    check("hold_idle", req_ready, 1);
    $display("hold sequence rden=%0d", rden_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
